mem_port_arbiter: RTL and testbench

- Arbitrates a single-ported unified instruction/data memory between two requesters: the instruction-fetch port (if_*) and the load/store data port (d_*).
- One transaction outstanding at a time; fixed-latency memory; registered grant and response.
- Data port has priority, with a starvation guard that guarantees fetch forward progress.
- Sits between the processor core and the shared memory array.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core (fetch and load/store ports), the arbiter and the shared memory.
// The slave modport is the arbiter's view. The master modport is the view of the core and memory.
interface mem_port_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
);
    logic                if_req;
    logic [ADDRSIZE-1:0] if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [WIDTH-1:0]    if_rdata;

    logic                d_req;
    logic                d_we;
    logic [ADDRSIZE-1:0] d_addr;
    logic [WIDTH-1:0]    d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [WIDTH-1:0]    d_rdata;

    logic                mem_en;
    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;

    logic                busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// The data port has priority. A starvation guard forces a fetch win after STARVE_MAX losses.
//
// state | meaning
// IDLE  | no transaction; requests are sampled here
// ISSUE | one cycle; gnt and mem_en are high for the latched winner
// WAIT  | counts MEM_LAT cycles; mem_rdata is captured in the last one
// RESP  | rvalid goes to the winner; requests are sampled again here
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDRSIZE   = 12,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q;
    logic                sel_d_q;
    logic [3:0]          starve_q;
    logic [2:0]          lat_q;
    logic                if_gnt_q, if_rvalid_q, d_gnt_q, d_rvalid_q;
    logic [WIDTH-1:0]    if_rdata_q, d_rdata_q;
    logic                mem_en_q, mem_we_q;
    logic [ADDRSIZE-1:0] mem_addr_q;
    logic [WIDTH-1:0]    mem_wdata_q;

    logic       req_any, pick_d;
    logic [3:0] starve_d;

    assign req_any = bus.if_req | bus.d_req;

    always_comb begin
        pick_d   = 1'b0;
        starve_d = starve_q;
        if (bus.d_req && bus.if_req) begin
            if (starve_q == 4'(STARVE_MAX)) begin
                starve_d = '0;
            end else begin
                pick_d   = 1'b1;
                starve_d = starve_q + 4'd1;
            end
        end else if (bus.d_req) begin
            pick_d = 1'b1;
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_d_q     <= 1'b0;
            starve_q    <= '0;
            lat_q       <= '0;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (req_any) begin
                        sel_d_q     <= pick_d;
                        starve_q    <= starve_d;
                        if_gnt_q    <= ~pick_d;
                        d_gnt_q     <= pick_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= pick_d & bus.d_we;
                        mem_addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
                        mem_wdata_q <= pick_d ? bus.d_wdata : '0;
                        state_q     <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    lat_q   <= 3'(MEM_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (lat_q == 3'd0) begin
                        if (sel_d_q) begin
                            d_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= bus.mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (MEM_LAT=1 and MEM_LAT=3), each with a delay-line memory model.
// The memory model drives read data only in the cycle that is exactly MEM_LAT cycles after mem_en.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst1_n, rst3_n;
    int   total = 0;
    int   passed = 0;

    mem_port_arbiter_if #(.WIDTH(32), .ADDRSIZE(12)) b1 ();
    mem_port_arbiter_if #(.WIDTH(32), .ADDRSIZE(12)) b3 ();

    mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(b1));
    mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(b3));

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [11:0] a);
        if (a == 12'h010)      return 32'hDEADBEEF;
        else if (a == 12'h004) return 32'h00000013;
        else                   return {20'hA5A5A, a};
    endfunction

    logic        pv1 = 1'b0;
    logic [31:0] pd1 = '0;
    logic [2:0]  pv3 = '0;
    logic [31:0] pd3 [3];

    always @(posedge clk) begin
        pv1 <= (b1.mem_en === 1'b1);
        pd1 <= memf(b1.mem_addr);
        pv3 <= {pv3[1:0], (b3.mem_en === 1'b1)};
        pd3[0] <= memf(b3.mem_addr);
        pd3[1] <= pd3[0];
        pd3[2] <= pd3[1];
    end
    assign b1.mem_rdata = pv1 ? pd1 : 32'hBAD0BAD0;
    assign b3.mem_rdata = pv3[2] ? pd3[2] : 32'hBAD0BAD0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int          n;
        int          grants;
        logic [9:0]  seq;
        logic        both;
        logic        saw_rv;

        b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
        rst1_n = 0; rst3_n = 0;

        // Reset held for 3 cycles with a load pending on the data port
        @(negedge clk);
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 12'h010;
        repeat (3) tick();
        chk("rst_flags", {b1.if_gnt, b1.if_rvalid, b1.d_gnt, b1.d_rvalid, b1.mem_en, b1.mem_we, b1.busy}, 0);
        chk("rst_rdata", {b1.if_rdata, b1.d_rdata}, 0);
        chk("rst_mem", {b1.mem_addr, b1.mem_wdata}, 0);

        // Single load, MEM_LAT=1
        rst1_n = 1; rst3_n = 1;
        tick();
        chk("ld_gnt", {b1.d_gnt, b1.if_gnt, b1.mem_en, b1.mem_we, b1.busy}, 5'b10101);
        chk("ld_addr", b1.mem_addr, 12'h010);
        b1.d_req = 0;
        tick();
        chk("ld_wait", {b1.d_gnt, b1.mem_en, b1.d_rvalid, b1.busy}, 4'b0001);
        tick();
        chk("ld_rvalid", {b1.d_rvalid, b1.if_rvalid, b1.busy}, 3'b101);
        chk("ld_rdata", b1.d_rdata, 32'hDEADBEEF);
        tick();
        chk("ld_idle", {b1.d_rvalid, b1.busy}, 2'b00);

        // Store, then a fetch that arrives one cycle later
        b1.d_req = 1; b1.d_we = 1; b1.d_addr = 12'h020; b1.d_wdata = 32'h12345678;
        tick();
        chk("st_gnt", {b1.d_gnt, b1.if_gnt, b1.mem_en, b1.mem_we}, 4'b1011);
        chk("st_mem", {b1.mem_addr, b1.mem_wdata}, {12'h020, 32'h12345678});
        b1.d_req = 0; b1.d_we = 0;
        b1.if_req = 1; b1.if_addr = 12'h004;
        tick();
        chk("st_wait", {b1.if_gnt, b1.d_rvalid}, 2'b00);
        tick();
        chk("st_rvalid", {b1.d_rvalid, b1.if_gnt}, 2'b10);
        chk("st_rdata", b1.d_rdata, 32'h0);
        tick();
        chk("f_gnt", {b1.if_gnt, b1.d_gnt, b1.mem_en, b1.mem_we}, 4'b1010);
        chk("f_mem", {b1.mem_addr, b1.mem_wdata}, {12'h004, 32'h0});
        b1.if_req = 0;
        tick();
        tick();
        chk("f_rvalid", {b1.if_rvalid, b1.d_rvalid}, 2'b10);
        chk("f_rdata", {b1.if_rdata, b1.d_rdata}, {32'h00000013, 32'h0});
        tick();

        // Starvation guard: both requesters held high continuously
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 12'h030;
        b1.if_req = 1; b1.if_addr = 12'h008;
        grants = 0; seq = '0; both = 0; n = 0;
        while (grants < 10 && n < 60) begin
            tick();
            n++;
            if (b1.if_gnt && b1.d_gnt) both = 1;
            if (b1.if_gnt || b1.d_gnt) begin
                seq = {seq[8:0], b1.if_gnt};
                grants++;
            end
        end
        b1.d_req = 0; b1.if_req = 0;
        chk("stv_count", grants, 10);
        chk("stv_order", seq, 10'b0000100001);
        chk("stv_both", both, 1'b0);
        repeat (3) tick();
        chk("stv_idle", b1.busy, 1'b0);

        // MEM_LAT=3 fetch
        b3.if_req = 1; b3.if_addr = 12'h004;
        tick();
        chk("l3_gnt", {b3.if_gnt, b3.mem_en, b3.mem_addr}, {2'b11, 12'h004});
        b3.if_req = 0;
        n = 0;
        while (!b3.if_rvalid && n < 10) begin
            tick();
            n++;
        end
        chk("l3_lat", n, 4);
        chk("l3_rdata", b3.if_rdata, 32'h00000013);

        // Reset asserted in the WAIT cycle of a load
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 12'h010;
        tick();
        chk("ab_gnt", b1.d_gnt, 1'b1);
        b1.d_req = 0;
        tick();
        rst1_n = 0;
        tick();
        chk("ab_flags", {b1.if_gnt, b1.if_rvalid, b1.d_gnt, b1.d_rvalid, b1.mem_en, b1.mem_we, b1.busy}, 0);
        chk("ab_data", {b1.d_rdata, b1.if_rdata, b1.mem_addr}, 0);
        rst1_n = 1;
        saw_rv = 0;
        repeat (6) begin
            tick();
            if (b1.d_rvalid || b1.busy) saw_rv = 1;
        end
        chk("ab_no_rvalid", saw_rv, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
